key_access_scheduler: RTL and testbench

KEY_ACCESS_SCHEDULER -- requirements
Module: key_access_scheduler

---
 rtl/key_access_scheduler_pkg.sv | 16 +
 rtl/key_access_scheduler_rr_arbiter.sv | 28 ++
 rtl/key_access_scheduler.sv | 137 +++++++++++++
 tb/tb_key_access_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_access_scheduler_pkg.sv
// Shared types and parameter defaults for the key access scheduler.
package key_access_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReady,
    StGranted,
    StZeroize
  } state_e;

  localparam int unsigned NumReqDefault   = 4;
  localparam int unsigned KeyWDefault     = 256;
  localparam int unsigned ZwDefault       = 32;
  localparam int unsigned LeaseMaxDefault = 255;

endpackage

// File: rtl/key_access_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins when advance is set.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (advance && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_access_scheduler.sv
// Holds one secret key, leases it to a single requester at a time, and erases it on demand.
module key_access_scheduler
  import key_access_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NumReqDefault,
  parameter int unsigned KEY_W     = KeyWDefault,
  parameter int unsigned LEASE_MAX = LeaseMaxDefault,
  parameter int unsigned ZW        = ZwDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               key_wr,
  output logic               key_wr_ack,
  input  logic               zeroize_req,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               zeroize_busy,
  output logic               lease_timeout
);

  localparam int unsigned PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LeaseW   = $clog2(LEASE_MAX + 1);
  localparam int unsigned NumWords = KEY_W / ZW;
  localparam int unsigned ZwIdxW   = (NumWords > 1) ? $clog2(NumWords) : 1;

  state_e              state_q;
  logic [KEY_W-1:0]    key_q;
  logic [LeaseW-1:0]   lease_q;
  logic [PtrW-1:0]     ptr_q;
  logic [PtrW-1:0]     next_ptr;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ZwIdxW-1:0]   zw_idx_q;
  logic                ack_q;
  logic                timeout_q;
  logic                arb_advance;
  logic                grantee_req;

  // Only arbitrate when a grant can actually be issued this cycle.
  assign arb_advance = (state_q == StReady) && !zeroize_req && !key_wr;
  assign grantee_req = |(req & gnt_q);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr_q),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  always_comb begin
    next_ptr = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) next_ptr = PtrW'((i + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      key_q     <= '0;
      lease_q   <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      zw_idx_q  <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (key_wr) begin
            key_q   <= key_in;
            ack_q   <= 1'b1;
            state_q <= StReady;
          end
        end
        StReady: begin
          if (zeroize_req) begin
            zw_idx_q <= '0;
            state_q  <= StZeroize;
          end else if (key_wr) begin
            key_q <= key_in;
            ack_q <= 1'b1;
          end else if (|req) begin
            gnt_q   <= arb_gnt;
            ptr_q   <= next_ptr;
            lease_q <= LeaseW'(LEASE_MAX);
            state_q <= StGranted;
          end
        end
        StGranted: begin
          if (zeroize_req) begin
            gnt_q    <= '0;
            zw_idx_q <= '0;
            state_q  <= StZeroize;
          end else if (!grantee_req) begin
            gnt_q   <= '0;
            state_q <= StReady;
          end else if (lease_q == '0) begin
            gnt_q     <= '0;
            timeout_q <= 1'b1;
            zw_idx_q  <= '0;
            state_q   <= StZeroize;
          end else begin
            lease_q <= lease_q - LeaseW'(1);
          end
        end
        StZeroize: begin
          for (int unsigned w = 0; w < NumWords; w++) begin
            if (zw_idx_q == ZwIdxW'(w)) key_q[w*ZW +: ZW] <= '0;
          end
          if (zw_idx_q == ZwIdxW'(NumWords - 1)) begin
            state_q <= StIdle;
          end else begin
            zw_idx_q <= zw_idx_q + ZwIdxW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt           = gnt_q;
  assign key_wr_ack    = ack_q;
  assign lease_timeout = timeout_q;
  assign key_valid     = (state_q == StReady) || (state_q == StGranted);
  assign zeroize_busy  = (state_q == StZeroize);
  assign key_out       = (state_q == StGranted) ? key_q : '0;

endmodule

// File: tb/tb_key_access_scheduler.sv
// Scenario bench for key_access_scheduler; grants are checked against a queue of expected grants.
module tb_key_access_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned KEY_W   = 256;

  localparam logic [KEY_W-1:0] KEY1 = {4{64'h0123456789abcdef}};
  localparam logic [KEY_W-1:0] KEY2 = {8{32'hdeadbeef}};
  localparam logic [KEY_W-1:0] KEY3 = {4{64'hfedcba9876543210}};
  localparam logic [KEY_W-1:0] KEY4 = {8{32'h5a5aa5a5}};
  localparam logic [KEY_W-1:0] KEY5 = {16{16'hc3c3}};

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [KEY_W-1:0]   key;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [KEY_W-1:0]   key_in = '0;
  logic               key_wr = 1'b0;
  logic               zeroize_req = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic               key_wr_ack;
  logic [NUM_REQ-1:0] gnt;
  logic [KEY_W-1:0]   key_out;
  logic               key_valid;
  logic               zeroize_busy;
  logic               lease_timeout;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t exp_q[$];
  logic [NUM_REQ-1:0] gnt_prev = '1;

  key_access_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .KEY_W     (KEY_W),
    .LEASE_MAX (4),
    .ZW        (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .key_wr        (key_wr),
    .key_wr_ack    (key_wr_ack),
    .zeroize_req   (zeroize_req),
    .req           (req),
    .gnt           (gnt),
    .key_out       (key_out),
    .key_valid     (key_valid),
    .zeroize_busy  (zeroize_busy),
    .lease_timeout (lease_timeout)
  );

  always #5 clk = ~clk;

  // Grant scoreboard: every new grant must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (gnt !== '0 && gnt_prev === '0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL grant_sb: got gnt %b, expected no grant", gnt);
      end else begin
        e = exp_q.pop_front();
        if (gnt !== e.gnt || key_out !== e.key) begin
          tests_failed++;
          $display("FAIL grant_sb: got gnt %b key %h, expected gnt %b key %h",
                   gnt, key_out, e.gnt, e.key);
        end
      end
    end
    gnt_prev = gnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [NUM_REQ-1:0] g, input logic [KEY_W-1:0] k);
    exp_t e;
    e.gnt = g;
    e.key = k;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_wr = 1'b0;
    zeroize_req = 1'b0;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write_key(input logic [KEY_W-1:0] k);
    key_in = k;
    key_wr = 1'b1;
    step();
    key_wr = 1'b0;
    tests_run++;
    if (key_wr_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_ack: got %b, expected 1", key_wr_ack);
    end
  endtask

  task automatic wait_gnt(output logic [NUM_REQ-1:0] g);
    int n = 0;
    step();
    while (gnt === '0 && n < 10) begin
      step();
      n++;
    end
    g = gnt;
    if (gnt === '0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_gnt: got no grant within 10 cycles, expected a grant");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_in = KEY1;
    key_wr = 1'b1;
    zeroize_req = 1'b1;
    req = '1;
    step();
    tests_run++;
    if ({gnt, key_wr_ack, lease_timeout, zeroize_busy, key_valid} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gnt %b ack %b to %b busy %b valid %b, expected all 0",
               gnt, key_wr_ack, lease_timeout, zeroize_busy, key_valid);
    end
    tests_run++;
    if (key_out !== '0 || dut.key_q !== '0) begin
      tests_failed++;
      $display("FAIL reset_key: got key_out %h key_q %h, expected 0", key_out, dut.key_q);
    end
    key_wr = 1'b0;
    zeroize_req = 1'b0;
    req = '0;
    step();
    rst = 1'b0;
    step();
    tests_run++;
    if (key_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_valid: got %b, expected 0", key_valid);
    end
  endtask

  task automatic test_write_grant();
    write_key(KEY1);
    tests_run++;
    if (key_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_valid: got %b, expected 1", key_valid);
    end
    step();
    tests_run++;
    if (key_wr_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_pulse: got %b, expected 0", key_wr_ack);
    end
    push_exp(4'b0001, KEY1);
    req = 4'b0001;
    step();
    tests_run++;
    if (gnt !== 4'b0001 || key_out !== KEY1) begin
      tests_failed++;
      $display("FAIL first_grant: got gnt %b key %h, expected 0001 key %h", gnt, key_out, KEY1);
    end
    req = '0;
    step();
    tests_run++;
    if (gnt !== '0 || key_out !== '0 || key_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL release: got gnt %b key %h valid %b, expected 0 0 1", gnt, key_out, key_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] g;
    do_reset();
    write_key(KEY1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_exp(4'(1 << (k % 4)), KEY1);
      wait_gnt(g);
      step();
      step();
      tests_run++;
      if (gnt !== g) begin
        tests_failed++;
        $display("FAIL rr_hold: got %b, expected %b", gnt, g);
      end
      req = 4'b1111 & ~g;
      step();
      tests_run++;
      if (gnt !== '0) begin
        tests_failed++;
        $display("FAIL rr_release: got %b, expected 0000", gnt);
      end
      req = 4'b1111;
    end
    req = '0;
    step();
  endtask

  task automatic test_lease_timeout();
    int gcycles = 0;
    int bcycles = 0;
    push_exp(4'b0100, KEY1);
    req = 4'b0100;
    step();
    while (gnt === 4'b0100 && gcycles < 20) begin
      gcycles++;
      step();
    end
    tests_run++;
    if (gcycles != 5) begin
      tests_failed++;
      $display("FAIL lease_len: got %0d granted cycles, expected 5", gcycles);
    end
    tests_run++;
    if (lease_timeout !== 1'b1 || zeroize_busy !== 1'b1 || gnt !== '0) begin
      tests_failed++;
      $display("FAIL lease_expire: got to %b busy %b gnt %b, expected 1 1 0000",
               lease_timeout, zeroize_busy, gnt);
    end
    while (zeroize_busy === 1'b1 && bcycles < 20) begin
      bcycles++;
      step();
      if (bcycles == 1) begin
        tests_run++;
        if (lease_timeout !== 1'b0) begin
          tests_failed++;
          $display("FAIL timeout_pulse: got %b, expected 0", lease_timeout);
        end
      end
    end
    tests_run++;
    if (bcycles != 8) begin
      tests_failed++;
      $display("FAIL zeroize_len: got %0d busy cycles, expected 8", bcycles);
    end
    tests_run++;
    if (key_valid !== 1'b0 || dut.key_q !== '0) begin
      tests_failed++;
      $display("FAIL lease_erased: got valid %b key_q %h, expected 0 0", key_valid, dut.key_q);
    end
    req = '0;
    step();
  endtask

  task automatic test_write_during_grant();
    write_key(KEY2);
    push_exp(4'b1000, KEY2);
    req = 4'b1000;
    step();
    key_in = KEY3;
    key_wr = 1'b1;
    step();
    key_wr = 1'b0;
    tests_run++;
    if (key_wr_ack !== 1'b0 || key_out !== KEY2 || gnt !== 4'b1000) begin
      tests_failed++;
      $display("FAIL wr_in_grant: got ack %b gnt %b key %h, expected 0 1000 key %h",
               key_wr_ack, gnt, key_out, KEY2);
    end
    req = '0;
    step();
    write_key(KEY3);
    push_exp(4'b0001, KEY3);
    req = 4'b0001;
    step();
    tests_run++;
    if (key_out !== KEY3) begin
      tests_failed++;
      $display("FAIL wr_after_release: got %h, expected %h", key_out, KEY3);
    end
    req = '0;
    step();
  endtask

  task automatic test_zeroize_vs_write();
    int bcycles = 0;
    key_in = KEY4;
    key_wr = 1'b1;
    zeroize_req = 1'b1;
    step();
    key_wr = 1'b0;
    zeroize_req = 1'b0;
    tests_run++;
    if (key_wr_ack !== 1'b0 || zeroize_busy !== 1'b1 || key_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_prio: got ack %b busy %b valid %b, expected 0 1 0",
               key_wr_ack, zeroize_busy, key_valid);
    end
    tests_run++;
    if (dut.key_q !== KEY3) begin
      tests_failed++;
      $display("FAIL zero_prio_key: got %h, expected %h", dut.key_q, KEY3);
    end
    while (zeroize_busy === 1'b1 && bcycles < 20) begin
      bcycles++;
      step();
    end
    tests_run++;
    if (bcycles != 8 || dut.key_q !== '0 || key_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done: got %0d cycles key_q %h valid %b, expected 8 0 0",
               bcycles, dut.key_q, key_valid);
    end
  endtask

  task automatic test_reset_mid_zeroize();
    zeroize_req = 1'b1;
    step();
    zeroize_req = 1'b0;
    tests_run++;
    if (zeroize_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_in_idle: got %b, expected 0", zeroize_busy);
    end
    write_key(KEY5);
    zeroize_req = 1'b1;
    step();
    zeroize_req = 1'b0;
    step();
    step();
    tests_run++;
    if (zeroize_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_zero_busy: got %b, expected 1", zeroize_busy);
    end
    rst = 1'b1;
    step();
    tests_run++;
    if (dut.state_q !== key_access_scheduler_pkg::StIdle || dut.key_q !== '0) begin
      tests_failed++;
      $display("FAIL rst_abort: got state %0d key_q %h, expected idle and 0",
               dut.state_q, dut.key_q);
    end
    tests_run++;
    if ({gnt, key_wr_ack, lease_timeout, zeroize_busy, key_valid} !== '0 || key_out !== '0) begin
      tests_failed++;
      $display("FAIL rst_abort_out: got gnt %b ack %b to %b busy %b valid %b, expected all 0",
               gnt, key_wr_ack, lease_timeout, zeroize_busy, key_valid);
    end
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_write_grant();
    test_round_robin();
    test_lease_timeout();
    test_write_during_grant();
    test_zeroize_vs_write();
    test_reset_mid_zeroize();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL grant_sb_drain: got %0d pending grants, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
